// File: rtl/divisor_seq.sv
// Sequential restoring divider: one quotient bit per CALC cycle, MSB first.
// A zero divisor completes in one cycle with Error set, Q all ones and R = A.
module divisor_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Error
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_err;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;
  logic             w_last;

  // After a successful subtract the remainder is below B, so diff[WIDTH] is zero.
  always_comb begin
    w_shift               = {r_rem, r_dvd[WIDTH-1]};
    {w_borrow, w_diff}    = {1'b0, w_shift} - {2'b00, r_b};
    w_ge                  = ~w_borrow & ~w_diff[WIDTH];
    w_rem_next            = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_dvd_next            = {r_dvd[WIDTH-2:0], w_ge};
    w_last                = (r_cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start)              w_state_next = (B == '0) ? DONE : CALC;
        else                    w_state_next = IDLE;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_rem <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (B == '0) begin
              r_q   <= '1;
              r_r   <= A;
              r_err <= 1'b1;
            end else begin
              r_dvd <= A;
              r_b   <= B;
              r_rem <= '0;
              r_cnt <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          r_dvd <= w_dvd_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CW'(1);
          // Visible results only move on the edge that enters DONE.
          if (w_last) begin
            r_q   <= w_dvd_next;
            r_r   <= w_rem_next;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Q     = r_q;
  assign R     = r_r;
  assign Error = r_err;

endmodule
